// File: rtl/smpl_test_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : smpl_test_ctrl
//  Purpose  : Issues samples into a fixed-latency test pipeline, counts the
//             hits that come back per triangle, and queues one count record
//             per triangle in a small FIFO. Credits are tracked so that a
//             returning record always has a free FIFO slot.
//  Ports    : clk, rst (async, active-low)
//             cfg_en_i                      - enable sample acceptance
//             smp_valid_i/smp_last_i/smp_ready_o/smp_go_o - sample handshake
//             hit_i                         - hit result in the return slot
//             rec_valid_o/rec_ready_i       - record handshake
//             rec_cnt_o/rec_tid_o/rec_sat_o - record payload
//             state_o (IDLE=0, RUN=1, DRAIN=2), idle_o
//  Revision : 1.0 - initial release
// ============================================================================
module smpl_test_ctrl #(
    parameter int PIPE_DEPTH = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16,
    parameter int TID_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_en_i,
    input  logic             smp_valid_i,
    input  logic             smp_last_i,
    output logic             smp_ready_o,
    output logic             smp_go_o,
    input  logic             hit_i,
    output logic             rec_valid_o,
    input  logic             rec_ready_i,
    output logic [CNT_W-1:0] rec_cnt_o,
    output logic [TID_W-1:0] rec_tid_o,
    output logic             rec_sat_o,
    output logic [1:0]       state_o,
    output logic             idle_o
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int LIF_W  = $clog2(PIPE_DEPTH + 1);
    localparam int CRED_W = FCNT_W + LIF_W;

    localparam logic [1:0]        c_IDLE    = 2'd0;
    localparam logic [1:0]        c_RUN     = 2'd1;
    localparam logic [1:0]        c_DRAIN   = 2'd2;
    localparam logic [CNT_W-1:0]  c_CNT_MAX = '1;
    localparam logic [CRED_W-1:0] c_CREDITS = CRED_W'(FIFO_DEPTH);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [PIPE_DEPTH-1:0] r_tag_v;
    logic [PIPE_DEPTH-1:0] r_tag_l;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_sat;
    logic [TID_W-1:0]      r_tid;

    logic [CNT_W-1:0]      r_mem_cnt [FIFO_DEPTH];
    logic [TID_W-1:0]      r_mem_tid [FIFO_DEPTH];
    logic                  r_mem_sat [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [FCNT_W-1:0]     r_fcount;

    logic                  w_ret_valid;
    logic                  w_ret_last;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_blocked;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_sat_nxt;
    logic [LIF_W-1:0]      w_lif;
    logic [CRED_W-1:0]     w_credit;
    logic                  w_in_flight;

    // ------------------------------------------------------------------
    // Credit check: every last in flight will need a FIFO slot when it
    // returns, so it is charged against the FIFO before it is issued.
    // ------------------------------------------------------------------
    always_comb begin
        w_lif = '0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            w_lif = w_lif + LIF_W'(r_tag_v[i] & r_tag_l[i]);
        end
    end

    assign w_credit    = CRED_W'(r_fcount) + CRED_W'(w_lif);
    assign w_in_flight = |r_tag_v;

    assign smp_ready_o = (r_state == c_RUN) && cfg_en_i && (w_credit < c_CREDITS);
    assign smp_go_o    = smp_valid_i & smp_ready_o;

    // Return slot is the oldest pipeline stage.
    assign w_ret_valid = r_tag_v[PIPE_DEPTH-1];
    assign w_ret_last  = r_tag_l[PIPE_DEPTH-1];

    // Saturating increment; a blocked increment sets the sticky flag.
    assign w_blocked = hit_i && (r_cnt == c_CNT_MAX);
    assign w_cnt_nxt = (hit_i && !w_blocked) ? (r_cnt + CNT_W'(1)) : r_cnt;
    assign w_sat_nxt = r_sat | w_blocked;

    assign w_push = w_ret_valid & w_ret_last;
    assign w_pop  = rec_valid_o & rec_ready_i;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (cfg_en_i) w_state_nxt = c_RUN;
            c_RUN:   if (!cfg_en_i) w_state_nxt = c_DRAIN;
            c_DRAIN: begin
                if (cfg_en_i) begin
                    w_state_nxt = c_RUN;
                end else if (!w_in_flight) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Tag pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag_v <= '0;
            r_tag_l <= '0;
        end else begin
            r_tag_v[0] <= smp_go_o;
            r_tag_l[0] <= smp_last_i;
            for (int i = PIPE_DEPTH - 1; i > 0; i--) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_l[i] <= r_tag_l[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-triangle hit counter. A partial count survives IDLE untouched.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
            r_tid <= '0;
        end else if (w_ret_valid) begin
            if (w_ret_last) begin
                r_cnt <= '0;
                r_sat <= 1'b0;
                r_tid <= r_tid + TID_W'(1);
            end else begin
                r_cnt <= w_cnt_nxt;
                r_sat <= w_sat_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Record FIFO (pointers wrap naturally: depth is a power of two)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_cnt[r_wr_ptr] <= w_cnt_nxt;
            r_mem_tid[r_wr_ptr] <= r_tid;
            r_mem_sat[r_wr_ptr] <= w_sat_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fcount <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_fcount <= r_fcount + FCNT_W'(1);
                2'b01:   r_fcount <= r_fcount - FCNT_W'(1);
                default: r_fcount <= r_fcount;
            endcase
        end
    end

    // Payload is forced to zero when empty so reset/empty outputs are clean.
    assign rec_valid_o = (r_fcount != '0);
    assign rec_cnt_o   = rec_valid_o ? r_mem_cnt[r_rd_ptr] : '0;
    assign rec_tid_o   = rec_valid_o ? r_mem_tid[r_rd_ptr] : '0;
    assign rec_sat_o   = rec_valid_o ? r_mem_sat[r_rd_ptr] : 1'b0;

    assign state_o = r_state;
    assign idle_o  = !w_in_flight && (r_fcount == '0);

endmodule
`default_nettype wire

// File: tb/tb_smpl_test_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_smpl_test_ctrl
//  Purpose  : Directed bench for smpl_test_ctrl. Two instances share the
//             stimulus: one with default widths, one with a 2-bit counter
//             to exercise saturation. A queue-based model predicts outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_smpl_test_ctrl;

    localparam int PD = 3;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cfg_en = 1'b0;
    logic smp_valid = 1'b0;
    logic smp_last = 1'b0;
    logic hit = 1'b0;
    logic rec_ready = 1'b0;

    logic        d_ready, d_go, d_rv, d_sat, d_idle;
    logic [15:0] d_cnt;
    logic [7:0]  d_tid;
    logic [1:0]  d_state;
    logic        s_ready, s_go, s_rv, s_sat, s_idle;
    logic [1:0]  s_cnt;
    logic [7:0]  s_tid;
    logic [1:0]  s_state;

    always #5 clk = ~clk;

    smpl_test_ctrl #(.PIPE_DEPTH(PD), .FIFO_DEPTH(FD), .CNT_W(16), .TID_W(8)) u_dut (
        .clk(clk), .rst(rst), .cfg_en_i(cfg_en), .smp_valid_i(smp_valid),
        .smp_last_i(smp_last), .smp_ready_o(d_ready), .smp_go_o(d_go), .hit_i(hit),
        .rec_valid_o(d_rv), .rec_ready_i(rec_ready), .rec_cnt_o(d_cnt),
        .rec_tid_o(d_tid), .rec_sat_o(d_sat), .state_o(d_state), .idle_o(d_idle)
    );

    smpl_test_ctrl #(.PIPE_DEPTH(PD), .FIFO_DEPTH(FD), .CNT_W(2), .TID_W(8)) u_sat (
        .clk(clk), .rst(rst), .cfg_en_i(cfg_en), .smp_valid_i(smp_valid),
        .smp_last_i(smp_last), .smp_ready_o(s_ready), .smp_go_o(s_go), .hit_i(hit),
        .rec_valid_o(s_rv), .rec_ready_i(rec_ready), .rec_cnt_o(s_cnt),
        .rec_tid_o(s_tid), .rec_sat_o(s_sat), .state_o(s_state), .idle_o(s_idle)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: samples in flight carry their due cycle; records are a queue.
    // Index 0 of the count arrays is the 16-bit instance, 1 the 2-bit one.
    // ------------------------------------------------------------------
    typedef struct { int due; bit last; } fl_t;
    typedef struct { int cnt0; int cnt1; int tid; bit sat0; bit sat1; } rec_t;

    fl_t  fq[$];
    rec_t rq[$];
    int   m_state = 0;
    int   m_cnt [2] = '{0, 0};
    bit   m_sat [2] = '{1'b0, 1'b0};
    int   m_tid = 0;
    int   cyc = 0;

    function automatic int m_lasts();
        int n = 0;
        foreach (fq[i]) if (fq[i].last) n++;
        return n;
    endfunction

    function automatic bit m_ready();
        return (m_state == 1) && cfg_en && ((rq.size() + m_lasts()) < FD);
    endfunction

    bit   u_go, u_rl;
    int   u_ns, u_max;
    fl_t  u_f;
    rec_t u_r;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            fq.delete();
            rq.delete();
            m_state = 0;
            m_cnt[0] = 0; m_cnt[1] = 0;
            m_sat[0] = 1'b0; m_sat[1] = 1'b0;
            m_tid = 0;
        end else begin
            u_go = m_ready() && smp_valid;
            u_ns = m_state;
            case (m_state)
                0: if (cfg_en) u_ns = 1;
                1: if (!cfg_en) u_ns = 2;
                default: if (cfg_en) u_ns = 1; else if (fq.size() == 0) u_ns = 0;
            endcase
            if (rq.size() > 0 && rec_ready) void'(rq.pop_front());
            if (fq.size() > 0 && fq[0].due == cyc) begin
                u_rl = fq[0].last;
                void'(fq.pop_front());
                for (int k = 0; k < 2; k++) begin
                    u_max = (k == 0) ? 65535 : 3;
                    if (hit) begin
                        if (m_cnt[k] == u_max) m_sat[k] = 1'b1;
                        else m_cnt[k] = m_cnt[k] + 1;
                    end
                end
                if (u_rl) begin
                    u_r.cnt0 = m_cnt[0]; u_r.cnt1 = m_cnt[1];
                    u_r.sat0 = m_sat[0]; u_r.sat1 = m_sat[1];
                    u_r.tid  = m_tid;
                    rq.push_back(u_r);
                    m_cnt[0] = 0; m_cnt[1] = 0;
                    m_sat[0] = 1'b0; m_sat[1] = 1'b0;
                    m_tid = (m_tid + 1) % 256;
                end
            end
            if (u_go) begin
                u_f.due  = cyc + PD;
                u_f.last = smp_last;
                fq.push_back(u_f);
            end
            m_state = u_ns;
        end
        if (rst) cyc++;
    end

    // ------------------------------------------------------------------
    // Compare process: every cycle, both instances against the model.
    // ------------------------------------------------------------------
    bit e_ready, e_go, e_rv, e_idle, e_sat0, e_sat1;
    int e_cnt0, e_cnt1, e_tid;

    always @(negedge clk) begin
        e_ready = m_ready();
        e_go    = e_ready && smp_valid;
        e_rv    = (rq.size() > 0);
        e_cnt0 = 0; e_cnt1 = 0; e_tid = 0; e_sat0 = 1'b0; e_sat1 = 1'b0;
        if (e_rv) begin
            e_cnt0 = rq[0].cnt0; e_cnt1 = rq[0].cnt1; e_tid = rq[0].tid;
            e_sat0 = rq[0].sat0; e_sat1 = rq[0].sat1;
        end
        e_idle = (fq.size() == 0) && (rq.size() == 0);
        chk("d_ready", 32'(d_ready), 32'(e_ready));
        chk("d_go",    32'(d_go),    32'(e_go));
        chk("d_rv",    32'(d_rv),    32'(e_rv));
        chk("d_cnt",   32'(d_cnt),   32'(e_cnt0));
        chk("d_tid",   32'(d_tid),   32'(e_tid));
        chk("d_sat",   32'(d_sat),   32'(e_sat0));
        chk("d_state", 32'(d_state), 32'(m_state));
        chk("d_idle",  32'(d_idle),  32'(e_idle));
        chk("s_ready", 32'(s_ready), 32'(e_ready));
        chk("s_go",    32'(s_go),    32'(e_go));
        chk("s_rv",    32'(s_rv),    32'(e_rv));
        chk("s_cnt",   32'(s_cnt),   32'(e_cnt1));
        chk("s_tid",   32'(s_tid),   32'(e_tid));
        chk("s_sat",   32'(s_sat),   32'(e_sat1));
        chk("s_state", 32'(s_state), 32'(m_state));
        chk("s_idle",  32'(s_idle),  32'(e_idle));
    end

    // ------------------------------------------------------------------
    // Stimulus with hand-computed literal expectations
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cfg_en = 1'b0; smp_valid = 1'b0; smp_last = 1'b0; hit = 1'b0; rec_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic go_run();
        cfg_en = 1'b1;
        tick();
    endtask

    initial begin
        // Reset with enable/valid asserted: nothing may be accepted.
        rst = 1'b0;
        cfg_en = 1'b1; smp_valid = 1'b1; smp_last = 1'b1; hit = 1'b1; rec_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_ready", 32'(d_ready), 32'd0);
        chk("rst_go",    32'(d_go),    32'd0);
        chk("rst_rv",    32'(d_rv),    32'd0);
        chk("rst_state", 32'(d_state), 32'd0);
        chk("rst_idle",  32'(d_idle),  32'd1);
        do_reset();

        // Basic: 4 samples, hits 1,0,1,1 -> cnt=3 in cycle 7
        go_run();
        rec_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            smp_valid = (c < 4); smp_last = (c == 3); hit = (c != 4);
            @(negedge clk);
            if (c == 0) chk("basic_ready0", 32'(d_ready), 32'd1);
            if (c == 6) chk("basic_rv6", 32'(d_rv), 32'd0);
            if (c == 7) begin
                chk("basic_rv7",  32'(d_rv),  32'd1);
                chk("basic_cnt",  32'(d_cnt), 32'd3);
                chk("basic_tid",  32'(d_tid), 32'd0);
                chk("basic_sat",  32'(d_sat), 32'd0);
            end
            tick();
        end
        do_reset();

        // Backpressure: one-sample triangles, FIFO fills at 4
        go_run();
        for (int c = 0; c < 20; c++) begin
            smp_valid = (c <= 11); smp_last = 1'b1; hit = 1'b1;
            rec_ready = (c == 10) || (c >= 12);
            @(negedge clk);
            if (c == 9) begin
                chk("bp_ready_low", 32'(d_ready), 32'd0);
                chk("bp_rv",        32'(d_rv),    32'd1);
                chk("bp_tid0",      32'(d_tid),   32'd0);
                chk("bp_cnt",       32'(d_cnt),   32'd1);
            end
            if (c == 11) begin
                chk("bp_ready_up", 32'(d_ready), 32'd1);
                chk("bp_go",       32'(d_go),    32'd1);
                chk("bp_tid1",     32'(d_tid),   32'd1);
            end
            if (c >= 12 && c <= 15) chk("bp_tid_order", 32'(d_tid), 32'(c - 11));
            tick();
        end
        do_reset();

        // Saturation: 5 hits on a 2-bit counter, then a fresh triangle
        go_run();
        rec_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            smp_valid = (c < 6); smp_last = (c == 4) || (c == 5); hit = 1'b1;
            @(negedge clk);
            if (c == 8) begin
                chk("sat_cnt",  32'(s_cnt), 32'd3);
                chk("sat_flag", 32'(s_sat), 32'd1);
                chk("sat_wide", 32'(d_cnt), 32'd5);
                chk("sat_wflg", 32'(d_sat), 32'd0);
            end
            if (c == 9) begin
                chk("sat_next_cnt", 32'(s_cnt), 32'd1);
                chk("sat_next_flg", 32'(s_sat), 32'd0);
                chk("sat_next_tid", 32'(s_tid), 32'd1);
            end
            tick();
        end
        do_reset();

        // Drain: enable drops with 2 samples in flight
        go_run();
        rec_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            cfg_en = (c < 2); smp_valid = (c < 5); smp_last = (c == 1); hit = 1'b1;
            @(negedge clk);
            if (c == 3) begin
                chk("drain_state", 32'(d_state), 32'd2);
                chk("drain_ready", 32'(d_ready), 32'd0);
            end
            if (c == 5) chk("drain_cnt", 32'(d_cnt), 32'd2);
            if (c == 6) begin
                chk("drain_idle_st", 32'(d_state), 32'd0);
                chk("drain_idle",    32'(d_idle),  32'd1);
            end
            tick();
        end
        do_reset();

        // Mid-triangle reset: partial triangle discarded, tid restarts at 0
        go_run();
        rec_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            rst = (c != 2);
            smp_valid = (c < 2) || (c >= 4 && c <= 6);
            smp_last = (c == 6); hit = (c != 9);
            @(negedge clk);
            if (c == 3) chk("mrst_state", 32'(d_state), 32'd0);
            if (c == 9) chk("mrst_rv9", 32'(d_rv), 32'd0);
            if (c == 10) begin
                chk("mrst_rv",  32'(d_rv),  32'd1);
                chk("mrst_tid", 32'(d_tid), 32'd0);
                chk("mrst_cnt", 32'(d_cnt), 32'd2);
            end
            tick();
        end
        do_reset();

        // Simultaneous push and pop with one stored record
        go_run();
        for (int c = 0; c < 9; c++) begin
            smp_valid = (c < 2); smp_last = 1'b1; hit = (c != 4);
            rec_ready = (c == 4) || (c == 6);
            @(negedge clk);
            if (c == 4) begin
                chk("pp_tidA", 32'(d_tid), 32'd0);
                chk("pp_cntA", 32'(d_cnt), 32'd1);
            end
            if (c == 5 || c == 6) begin
                chk("pp_rv",   32'(d_rv),  32'd1);
                chk("pp_tidB", 32'(d_tid), 32'd1);
                chk("pp_cntB", 32'(d_cnt), 32'd0);
            end
            if (c == 7) begin
                chk("pp_empty", 32'(d_rv),   32'd0);
                chk("pp_idle",  32'(d_idle), 32'd1);
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/smpl_test_ctrl.md
SMPL_TEST_CTRL -- requirements
Module: smpl_test_ctrl

Interface
REQ-001 The module SHALL have the following parameters, one per line:
  - PIPE_DEPTH, default 3, fixed latency of the sample-test pipeline.
  - FIFO_DEPTH, default 4, number of count-record entries (power of two, at least 2).
  - CNT_W, default 16, hit-counter width.
  - TID_W, default 8, triangle-id width.
REQ-002 The module SHALL have the following ports, one per line:
  - clk  in  1  clock; one clock domain.
  - rst  in  1  asynchronous, active-low reset.
  - cfg_en_i  in  1  enables sample acceptance.
  - smp_valid_i  in  1  upstream sample valid.
  - smp_last_i  in  1  sample is the last of its triangle.
  - smp_ready_o  out  1  controller accepts a sample.
  - smp_go_o  out  1  sample issued to the test pipeline (smp_valid_i & smp_ready_o).
  - hit_i  in  1  pipeline hit result; meaningful only in return slots.
  - rec_valid_o  out  1  count record available.
  - rec_ready_i  in  1  downstream consumes the record.
  - rec_cnt_o  out  CNT_W  hits in the triangle.
  - rec_tid_o  out  TID_W  triangle id.
  - rec_sat_o  out  1  count saturated.
  - state_o  out  2  FSM state (IDLE=0, RUN=1, DRAIN=2).
  - idle_o  out  1  no samples in flight and FIFO empty.

Function
REQ-003 A sample SHALL be accepted in any cycle where smp_valid_i and smp_ready_o are both 1; smp_go_o SHALL equal that product combinationally.
REQ-004 smp_ready_o SHALL be 1 only when all of the following hold: state==RUN, cfg_en_i==1, and fifo_count + lasts_in_flight < FIFO_DEPTH.
REQ-005 The module SHALL keep a PIPE_DEPTH-stage shift register of {valid, last} tags, loaded with {smp_go_o, smp_last_i}; the tag accepted in cycle t SHALL appear at the output stage in cycle t+PIPE_DEPTH (the return slot).
REQ-006 hit_i SHALL be counted only in a return slot whose valid tag is 1; in all other cycles it SHALL be ignored.
REQ-007 The running count SHALL increment by hit_i in each valid return slot and saturate at 2^CNT_W-1; a sticky sat flag SHALL be set when an increment is blocked by saturation.
REQ-008 In a valid return slot with last==1, the module SHALL push {count+hit_i (saturated), current tid, sat} into the FIFO at that clock edge, then clear count and sat and increment tid (modulo 2^TID_W).
REQ-009 The pushed record SHALL appear on the outputs no earlier than cycle t+PIPE_DEPTH+1 when the FIFO was empty; the total latency from the last sample's acceptance to rec_valid_o is therefore PIPE_DEPTH+1 cycles.
REQ-010 The FIFO SHALL pop on rec_valid_o & rec_ready_i, and rec_* SHALL hold stable while rec_valid_o=1 and rec_ready_i=0.
REQ-011 A push and a pop in the same cycle SHALL both take effect with fifo_count unchanged; the credit rule of REQ-004 guarantees a push never meets a full FIFO.
REQ-012 FSM transitions SHALL be:
  - IDLE->RUN when cfg_en_i=1.
  - RUN->DRAIN when cfg_en_i=0.
  - DRAIN->IDLE when no valid tags remain in flight.
  - DRAIN->RUN when cfg_en_i=1 again.
REQ-013 While in DRAIN, returning hits and lasts SHALL be processed normally, and the FIFO SHALL keep draining.
REQ-014 A partially counted triangle (no last seen) SHALL keep its count across IDLE and resume on re-enable.
REQ-015 idle_o SHALL be 1 exactly when no valid tags are in flight and fifo_count==0.

Reset
REQ-016 While rst=0, the following SHALL be cleared: all tags, count, sat, tid, the FIFO pointers and count; state SHALL be IDLE.
REQ-017 While rst=0, the outputs SHALL be: smp_ready_o=0, smp_go_o=0, rec_valid_o=0, rec_cnt_o=0, rec_tid_o=0, rec_sat_o=0, state_o=0, idle_o=1.
REQ-018 Reset asserted mid-operation SHALL discard in-flight samples and stored records with no record emitted afterward; operation SHALL restart with tid=0.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
  - Basic: cfg_en_i=1, 4 samples accepted cycles 0-3 with last on the 4th, hit_i=1,0,1,1 in cycles 3-6, rec_ready_i=1 -> record cnt=3, tid=0, sat=0 with rec_valid_o in cycle 7.
  - Backpressure: rec_ready_i=0, 5 one-sample triangles each with hit=1 -> 4 records are stored and smp_ready_o drops after the 4th last is accepted; one pop re-raises smp_ready_o in the next cycle; tids are 0..3 in order.
  - Saturation: CNT_W=2, 5 hits in one triangle -> cnt=3, sat=1; the next triangle has sat=0.
  - Drain: deassert cfg_en_i with 2 samples in flight -> state DRAIN, smp_ready_o=0, the records complete, then IDLE with idle_o=1.
  - Mid-triangle reset: rst=0 for one cycle after 2 of 3 samples -> no record emitted; the next triangle reports tid=0 with a correct count.
  - Simultaneous push/pop with the FIFO at 1 entry -> fifo_count stays 1 and order is preserved.
